// File: rtl/ysyx_23060124_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI4 arbiter: FSM encoding,
// AXI response codes and channel field widths.
package ysyx_23060124_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_IFU = 2'd1,
    ST_RD_LSU = 2'd2,
    ST_WR_LSU = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;

  // An LSU grant always serves a pending store before a pending load.
  function automatic arb_state_e lsu_grant_state(input logic aw_valid);
    arb_state_e st;
    if (aw_valid) begin
      st = ST_WR_LSU;
    end else begin
      st = ST_RD_LSU;
    end
    return st;
  endfunction

endpackage

// File: rtl/ysyx_23060124_axi_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the master that did not win
// most recently is granted.
module ysyx_23060124_rr_pick2 (
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic last_lsu,
  output logic grant_ifu,
  output logic grant_lsu
);

  // Select at most one winner from the two requests.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (ifu_req && lsu_req) begin
      if (last_lsu) begin
        grant_ifu = 1'b1;
      end else begin
        grant_lsu = 1'b1;
      end
    end else if (ifu_req) begin
      grant_ifu = 1'b1;
    end else if (lsu_req) begin
      grant_lsu = 1'b1;
    end else begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_23060124_axi_arbiter.sv
// IFU/LSU to memory AXI4 arbiter. One transaction at a time; the
// granted master's channels are wired straight through to M_AXI.
module ysyx_23060124_axi_arbiter
  import ysyx_23060124_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  i_rst,
  // IFU read
  input  logic [ADDR_W-1:0]     S0_AXI_ARADDR,
  input  logic                  S0_AXI_ARVALID,
  input  logic [ID_W-1:0]       S0_AXI_ARID,
  input  logic [LEN_W-1:0]      S0_AXI_ARLEN,
  input  logic [SIZE_W-1:0]     S0_AXI_ARSIZE,
  input  logic [BURST_W-1:0]    S0_AXI_ARBURST,
  output logic                  S0_AXI_ARREADY,
  output logic [DATA_W-1:0]     S0_AXI_RDATA,
  output logic [1:0]            S0_AXI_RRESP,
  output logic                  S0_AXI_RVALID,
  output logic [ID_W-1:0]       S0_AXI_RID,
  output logic                  S0_AXI_RLAST,
  input  logic                  S0_AXI_RREADY,
  // LSU read
  input  logic [ADDR_W-1:0]     S1_AXI_ARADDR,
  input  logic                  S1_AXI_ARVALID,
  input  logic [ID_W-1:0]       S1_AXI_ARID,
  input  logic [LEN_W-1:0]      S1_AXI_ARLEN,
  input  logic [SIZE_W-1:0]     S1_AXI_ARSIZE,
  input  logic [BURST_W-1:0]    S1_AXI_ARBURST,
  output logic                  S1_AXI_ARREADY,
  output logic [DATA_W-1:0]     S1_AXI_RDATA,
  output logic [1:0]            S1_AXI_RRESP,
  output logic                  S1_AXI_RVALID,
  output logic [ID_W-1:0]       S1_AXI_RID,
  output logic                  S1_AXI_RLAST,
  input  logic                  S1_AXI_RREADY,
  // LSU write
  input  logic [ADDR_W-1:0]     S1_AXI_AWADDR,
  input  logic                  S1_AXI_AWVALID,
  input  logic [LEN_W-1:0]      S1_AXI_AWLEN,
  input  logic [SIZE_W-1:0]     S1_AXI_AWSIZE,
  input  logic [BURST_W-1:0]    S1_AXI_AWBURST,
  input  logic [ID_W-1:0]       S1_AXI_AWID,
  output logic                  S1_AXI_AWREADY,
  input  logic                  S1_AXI_WVALID,
  input  logic [DATA_W-1:0]     S1_AXI_WDATA,
  input  logic [DATA_W/8-1:0]   S1_AXI_WSTRB,
  input  logic                  S1_AXI_WLAST,
  output logic                  S1_AXI_WREADY,
  output logic [1:0]            S1_AXI_BRESP,
  output logic                  S1_AXI_BVALID,
  output logic [ID_W-1:0]       S1_AXI_BID,
  input  logic                  S1_AXI_BREADY,
  // Memory side
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  output logic [ID_W-1:0]       M_AXI_ARID,
  output logic [LEN_W-1:0]      M_AXI_ARLEN,
  output logic [SIZE_W-1:0]     M_AXI_ARSIZE,
  output logic [BURST_W-1:0]    M_AXI_ARBURST,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  input  logic [ID_W-1:0]       M_AXI_RID,
  input  logic                  M_AXI_RLAST,
  output logic                  M_AXI_RREADY,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  output logic [LEN_W-1:0]      M_AXI_AWLEN,
  output logic [SIZE_W-1:0]     M_AXI_AWSIZE,
  output logic [BURST_W-1:0]    M_AXI_AWBURST,
  output logic [ID_W-1:0]       M_AXI_AWID,
  input  logic                  M_AXI_AWREADY,
  output logic                  M_AXI_WVALID,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  input  logic [ID_W-1:0]       M_AXI_BID,
  output logic                  M_AXI_BREADY
);

  arb_state_e state_r;
  logic       last_lsu_r;
  logic       grant_ifu_s;
  logic       grant_lsu_s;
  logic       r_done_s;
  logic       b_done_s;

  ysyx_23060124_rr_pick2 u_pick (
    .ifu_req   (S0_AXI_ARVALID),
    .lsu_req   (S1_AXI_ARVALID | S1_AXI_AWVALID),
    .last_lsu  (last_lsu_r),
    .grant_ifu (grant_ifu_s),
    .grant_lsu (grant_lsu_s)
  );

  assign r_done_s = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST;
  assign b_done_s = M_AXI_BVALID & M_AXI_BREADY;

  // Grant FSM: arbitrate in IDLE, hold the grant until the final R or B handshake.
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      last_lsu_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_ifu_s) begin
            state_r    <= ST_RD_IFU;
            last_lsu_r <= 1'b0;
          end else if (grant_lsu_s) begin
            state_r    <= lsu_grant_state(S1_AXI_AWVALID);
            last_lsu_r <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_RD_IFU, ST_RD_LSU: begin
          if (r_done_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_WR_LSU: begin
          if (b_done_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WR_LSU;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Channel routing: everything closed and zeroed unless the state routes it.
  always_comb begin
    S0_AXI_ARREADY = 1'b0;
    S0_AXI_RDATA   = {DATA_W{1'b0}};
    S0_AXI_RRESP   = 2'b00;
    S0_AXI_RVALID  = 1'b0;
    S0_AXI_RID     = {ID_W{1'b0}};
    S0_AXI_RLAST   = 1'b0;
    S1_AXI_ARREADY = 1'b0;
    S1_AXI_RDATA   = {DATA_W{1'b0}};
    S1_AXI_RRESP   = 2'b00;
    S1_AXI_RVALID  = 1'b0;
    S1_AXI_RID     = {ID_W{1'b0}};
    S1_AXI_RLAST   = 1'b0;
    S1_AXI_AWREADY = 1'b0;
    S1_AXI_WREADY  = 1'b0;
    S1_AXI_BRESP   = 2'b00;
    S1_AXI_BVALID  = 1'b0;
    S1_AXI_BID     = {ID_W{1'b0}};
    M_AXI_ARADDR   = {ADDR_W{1'b0}};
    M_AXI_ARVALID  = 1'b0;
    M_AXI_ARID     = {ID_W{1'b0}};
    M_AXI_ARLEN    = {LEN_W{1'b0}};
    M_AXI_ARSIZE   = {SIZE_W{1'b0}};
    M_AXI_ARBURST  = {BURST_W{1'b0}};
    M_AXI_RREADY   = 1'b0;
    M_AXI_AWADDR   = {ADDR_W{1'b0}};
    M_AXI_AWVALID  = 1'b0;
    M_AXI_AWLEN    = {LEN_W{1'b0}};
    M_AXI_AWSIZE   = {SIZE_W{1'b0}};
    M_AXI_AWBURST  = {BURST_W{1'b0}};
    M_AXI_AWID     = {ID_W{1'b0}};
    M_AXI_WVALID   = 1'b0;
    M_AXI_WDATA    = {DATA_W{1'b0}};
    M_AXI_WSTRB    = {(DATA_W/8){1'b0}};
    M_AXI_WLAST    = 1'b0;
    M_AXI_BREADY   = 1'b0;
    case (state_r)
      ST_RD_IFU: begin
        M_AXI_ARADDR   = S0_AXI_ARADDR;
        M_AXI_ARVALID  = S0_AXI_ARVALID;
        M_AXI_ARID     = S0_AXI_ARID;
        M_AXI_ARLEN    = S0_AXI_ARLEN;
        M_AXI_ARSIZE   = S0_AXI_ARSIZE;
        M_AXI_ARBURST  = S0_AXI_ARBURST;
        S0_AXI_ARREADY = M_AXI_ARREADY;
        S0_AXI_RDATA   = M_AXI_RDATA;
        S0_AXI_RRESP   = M_AXI_RRESP;
        S0_AXI_RVALID  = M_AXI_RVALID;
        S0_AXI_RID     = M_AXI_RID;
        S0_AXI_RLAST   = M_AXI_RLAST;
        M_AXI_RREADY   = S0_AXI_RREADY;
      end
      ST_RD_LSU: begin
        M_AXI_ARADDR   = S1_AXI_ARADDR;
        M_AXI_ARVALID  = S1_AXI_ARVALID;
        M_AXI_ARID     = S1_AXI_ARID;
        M_AXI_ARLEN    = S1_AXI_ARLEN;
        M_AXI_ARSIZE   = S1_AXI_ARSIZE;
        M_AXI_ARBURST  = S1_AXI_ARBURST;
        S1_AXI_ARREADY = M_AXI_ARREADY;
        S1_AXI_RDATA   = M_AXI_RDATA;
        S1_AXI_RRESP   = M_AXI_RRESP;
        S1_AXI_RVALID  = M_AXI_RVALID;
        S1_AXI_RID     = M_AXI_RID;
        S1_AXI_RLAST   = M_AXI_RLAST;
        M_AXI_RREADY   = S1_AXI_RREADY;
      end
      ST_WR_LSU: begin
        M_AXI_AWADDR   = S1_AXI_AWADDR;
        M_AXI_AWVALID  = S1_AXI_AWVALID;
        M_AXI_AWLEN    = S1_AXI_AWLEN;
        M_AXI_AWSIZE   = S1_AXI_AWSIZE;
        M_AXI_AWBURST  = S1_AXI_AWBURST;
        M_AXI_AWID     = S1_AXI_AWID;
        S1_AXI_AWREADY = M_AXI_AWREADY;
        M_AXI_WVALID   = S1_AXI_WVALID;
        M_AXI_WDATA    = S1_AXI_WDATA;
        M_AXI_WSTRB    = S1_AXI_WSTRB;
        M_AXI_WLAST    = S1_AXI_WLAST;
        S1_AXI_WREADY  = M_AXI_WREADY;
        S1_AXI_BRESP   = M_AXI_BRESP;
        S1_AXI_BVALID  = M_AXI_BVALID;
        S1_AXI_BID     = M_AXI_BID;
        M_AXI_BREADY   = S1_AXI_BREADY;
      end
      default: M_AXI_ARVALID = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060124_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter. Inputs change on the
// falling clock edge, outputs are sampled 1-2 time units later.
module tb_ysyx_23060124_axi_arbiter;
  import ysyx_23060124_axi_arbiter_pkg::*;

  logic clock = 1'b0;
  logic i_rst;
  always #5 clock = ~clock;

  logic [31:0] S0_AXI_ARADDR;  logic S0_AXI_ARVALID; logic [3:0] S0_AXI_ARID;
  logic [7:0]  S0_AXI_ARLEN;   logic [2:0] S0_AXI_ARSIZE; logic [1:0] S0_AXI_ARBURST;
  logic S0_AXI_ARREADY; logic [31:0] S0_AXI_RDATA; logic [1:0] S0_AXI_RRESP;
  logic S0_AXI_RVALID; logic [3:0] S0_AXI_RID; logic S0_AXI_RLAST; logic S0_AXI_RREADY;
  logic [31:0] S1_AXI_ARADDR;  logic S1_AXI_ARVALID; logic [3:0] S1_AXI_ARID;
  logic [7:0]  S1_AXI_ARLEN;   logic [2:0] S1_AXI_ARSIZE; logic [1:0] S1_AXI_ARBURST;
  logic S1_AXI_ARREADY; logic [31:0] S1_AXI_RDATA; logic [1:0] S1_AXI_RRESP;
  logic S1_AXI_RVALID; logic [3:0] S1_AXI_RID; logic S1_AXI_RLAST; logic S1_AXI_RREADY;
  logic [31:0] S1_AXI_AWADDR; logic S1_AXI_AWVALID; logic [7:0] S1_AXI_AWLEN;
  logic [2:0] S1_AXI_AWSIZE; logic [1:0] S1_AXI_AWBURST; logic [3:0] S1_AXI_AWID;
  logic S1_AXI_AWREADY; logic S1_AXI_WVALID; logic [31:0] S1_AXI_WDATA;
  logic [3:0] S1_AXI_WSTRB; logic S1_AXI_WLAST; logic S1_AXI_WREADY;
  logic [1:0] S1_AXI_BRESP; logic S1_AXI_BVALID; logic [3:0] S1_AXI_BID; logic S1_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR; logic M_AXI_ARVALID; logic [3:0] M_AXI_ARID;
  logic [7:0] M_AXI_ARLEN; logic [2:0] M_AXI_ARSIZE; logic [1:0] M_AXI_ARBURST;
  logic M_AXI_ARREADY; logic [31:0] M_AXI_RDATA; logic [1:0] M_AXI_RRESP;
  logic M_AXI_RVALID; logic [3:0] M_AXI_RID; logic M_AXI_RLAST; logic M_AXI_RREADY;
  logic [31:0] M_AXI_AWADDR; logic M_AXI_AWVALID; logic [7:0] M_AXI_AWLEN;
  logic [2:0] M_AXI_AWSIZE; logic [1:0] M_AXI_AWBURST; logic [3:0] M_AXI_AWID;
  logic M_AXI_AWREADY; logic M_AXI_WVALID; logic [31:0] M_AXI_WDATA;
  logic [3:0] M_AXI_WSTRB; logic M_AXI_WLAST; logic M_AXI_WREADY;
  logic [1:0] M_AXI_BRESP; logic M_AXI_BVALID; logic [3:0] M_AXI_BID; logic M_AXI_BREADY;

  ysyx_23060124_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .i_rst(i_rst),
    .S0_AXI_ARADDR(S0_AXI_ARADDR), .S0_AXI_ARVALID(S0_AXI_ARVALID), .S0_AXI_ARID(S0_AXI_ARID),
    .S0_AXI_ARLEN(S0_AXI_ARLEN), .S0_AXI_ARSIZE(S0_AXI_ARSIZE), .S0_AXI_ARBURST(S0_AXI_ARBURST),
    .S0_AXI_ARREADY(S0_AXI_ARREADY), .S0_AXI_RDATA(S0_AXI_RDATA), .S0_AXI_RRESP(S0_AXI_RRESP),
    .S0_AXI_RVALID(S0_AXI_RVALID), .S0_AXI_RID(S0_AXI_RID), .S0_AXI_RLAST(S0_AXI_RLAST),
    .S0_AXI_RREADY(S0_AXI_RREADY),
    .S1_AXI_ARADDR(S1_AXI_ARADDR), .S1_AXI_ARVALID(S1_AXI_ARVALID), .S1_AXI_ARID(S1_AXI_ARID),
    .S1_AXI_ARLEN(S1_AXI_ARLEN), .S1_AXI_ARSIZE(S1_AXI_ARSIZE), .S1_AXI_ARBURST(S1_AXI_ARBURST),
    .S1_AXI_ARREADY(S1_AXI_ARREADY), .S1_AXI_RDATA(S1_AXI_RDATA), .S1_AXI_RRESP(S1_AXI_RRESP),
    .S1_AXI_RVALID(S1_AXI_RVALID), .S1_AXI_RID(S1_AXI_RID), .S1_AXI_RLAST(S1_AXI_RLAST),
    .S1_AXI_RREADY(S1_AXI_RREADY),
    .S1_AXI_AWADDR(S1_AXI_AWADDR), .S1_AXI_AWVALID(S1_AXI_AWVALID), .S1_AXI_AWLEN(S1_AXI_AWLEN),
    .S1_AXI_AWSIZE(S1_AXI_AWSIZE), .S1_AXI_AWBURST(S1_AXI_AWBURST), .S1_AXI_AWID(S1_AXI_AWID),
    .S1_AXI_AWREADY(S1_AXI_AWREADY), .S1_AXI_WVALID(S1_AXI_WVALID), .S1_AXI_WDATA(S1_AXI_WDATA),
    .S1_AXI_WSTRB(S1_AXI_WSTRB), .S1_AXI_WLAST(S1_AXI_WLAST), .S1_AXI_WREADY(S1_AXI_WREADY),
    .S1_AXI_BRESP(S1_AXI_BRESP), .S1_AXI_BVALID(S1_AXI_BVALID), .S1_AXI_BID(S1_AXI_BID),
    .S1_AXI_BREADY(S1_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARID(M_AXI_ARID),
    .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RID(M_AXI_RID), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWID(M_AXI_AWID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BID(M_AXI_BID),
    .M_AXI_BREADY(M_AXI_BREADY)
  );

  int checks = 0;
  int passes = 0;

  // OR of every handshake output of the arbiter.
  function automatic logic ctl_any();
    return |{M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
             S0_AXI_ARREADY, S0_AXI_RVALID, S1_AXI_ARREADY, S1_AXI_RVALID,
             S1_AXI_AWREADY, S1_AXI_WREADY, S1_AXI_BVALID};
  endfunction

  // Wait (bounded) for M_AXI_ARVALID, accept the address, drop the winner's ARVALID.
  task automatic ar_handshake(output int cycles, output bit to_s1,
                              output logic [31:0] addr, output logic [7:0] len);
    cycles = 0;
    #1;
    while (M_AXI_ARVALID !== 1'b1 && cycles < 20) begin
      @(negedge clock); #1; cycles++;
    end
    addr = M_AXI_ARADDR;
    len  = M_AXI_ARLEN;
    M_AXI_ARREADY = 1'b1;
    #1;
    to_s1 = (S1_AXI_ARREADY === 1'b1);
    @(negedge clock);
    M_AXI_ARREADY = 1'b0;
    if (to_s1) S1_AXI_ARVALID = 1'b0;
    else       S0_AXI_ARVALID = 1'b0;
  endtask

  // Slave side: present nbeats R beats; count beats delivered intact to the granted master.
  task automatic serve_read(input bit to_s1, input int nbeats, input int last_idx,
                            input logic [31:0] base, input logic [1:0] resp, input int stall_beat,
                            output int good, output int other, output int stall_ok,
                            output logic [1:0] seen_resp);
    logic [31:0] exp_data;
    logic [3:0]  exp_id;
    good = 0; other = 0; stall_ok = 0; seen_resp = RESP_DECERR;
    exp_id = to_s1 ? 4'h5 : 4'h3;
    for (int i = 0; i < nbeats; i++) begin
      exp_data = base + 32'(i);
      M_AXI_RVALID = 1'b1; M_AXI_RDATA = exp_data; M_AXI_RRESP = resp;
      M_AXI_RID = exp_id; M_AXI_RLAST = (i == last_idx);
      if (i == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          S0_AXI_RREADY = 1'b0; S1_AXI_RREADY = 1'b0;
          #1;
          if (M_AXI_RREADY === 1'b0 && (to_s1 ? S1_AXI_RVALID : S0_AXI_RVALID) === 1'b1)
            stall_ok++;
          @(negedge clock);
        end
      end
      S0_AXI_RREADY = 1'b1; S1_AXI_RREADY = 1'b1;
      #1;
      if (to_s1) begin
        if (S1_AXI_RVALID === 1'b1 && S1_AXI_RDATA === exp_data && S1_AXI_RID === exp_id &&
            S1_AXI_RLAST === (i == last_idx) && M_AXI_RREADY === 1'b1) good++;
        if (S0_AXI_RVALID !== 1'b0) other++;
        seen_resp = S1_AXI_RRESP;
      end else begin
        if (S0_AXI_RVALID === 1'b1 && S0_AXI_RDATA === exp_data && S0_AXI_RID === exp_id &&
            S0_AXI_RLAST === (i == last_idx) && M_AXI_RREADY === 1'b1) good++;
        if (S1_AXI_RVALID !== 1'b0) other++;
        seen_resp = S0_AXI_RRESP;
      end
      @(negedge clock);
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
  endtask

  int cyc, good, other, stall_ok;
  bit to_s1;
  logic [31:0] addr;
  logic [7:0] len;
  logic [1:0] rresp;

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge clock);
    S0_AXI_ARVALID = 1'b1; M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1; S0_AXI_RREADY = 1'b1;
    #1;
    checks++;
    if (ctl_any() !== 1'b0) $display("FAIL reset_ctl_zero: got %b want 0", ctl_any());
    else passes++;
    @(negedge clock);
    S0_AXI_ARVALID = 1'b0; M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; i_rst = 1'b0;
    @(negedge clock);
    // LSU 4-beat burst, reset lands on beat 2
    S1_AXI_ARVALID = 1'b1; S1_AXI_ARADDR = 32'h8000_1000; S1_AXI_ARLEN = 8'd3;
    ar_handshake(cyc, to_s1, addr, len);
    checks++;
    if (to_s1 !== 1'b1) $display("FAIL rst_lsu_grant: got %b want 1", to_s1);
    else passes++;
    serve_read(1'b1, 1, 3, 32'h1111_0000, RESP_OKAY, -1, good, other, stall_ok, rresp);
    M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h1111_0001; i_rst = 1'b1;
    #1;
    checks++;
    if (ctl_any() !== 1'b0 || M_AXI_ARADDR !== 32'h0 || S1_AXI_RDATA !== 32'h0)
      $display("FAIL rst_mid_burst_zero: ctl=%b araddr=%h rdata=%h want 0", ctl_any(), M_AXI_ARADDR, S1_AXI_RDATA);
    else passes++;
    @(negedge clock);
    i_rst = 1'b0; M_AXI_RVALID = 1'b0;
    S0_AXI_ARVALID = 1'b1; S0_AXI_ARADDR = 32'h3000_0100; S0_AXI_ARLEN = 8'd0;
    ar_handshake(cyc, to_s1, addr, len);
    checks++;
    if (cyc !== 1 || to_s1 !== 1'b0) $display("FAIL rst_ifu_grant: got lat=%0d s1=%b want lat=1 s1=0", cyc, to_s1);
    else passes++;
    serve_read(1'b0, 1, 0, 32'h2222_0000, RESP_OKAY, -1, good, other, stall_ok, rresp);
    checks++;
    if (good !== 1) $display("FAIL rst_ifu_beat: got %0d want 1", good);
    else passes++;
  endtask

  task automatic test_tie();
    @(negedge clock); i_rst = 1'b1;
    @(negedge clock); i_rst = 1'b0;
    S0_AXI_ARVALID = 1'b1; S0_AXI_ARADDR = 32'h3000_0200; S0_AXI_ARLEN = 8'd1;
    S1_AXI_ARVALID = 1'b1; S1_AXI_ARADDR = 32'h8000_2000; S1_AXI_ARLEN = 8'd0;
    ar_handshake(cyc, to_s1, addr, len);
    checks++;
    if (to_s1 !== 1'b0 || addr !== 32'h3000_0200) $display("FAIL tie_ifu_first: got s1=%b addr=%h want s1=0 addr=30000200", to_s1, addr);
    else passes++;
    serve_read(1'b0, 2, 1, 32'h3333_0000, RESP_OKAY, -1, good, other, stall_ok, rresp);
    checks++;
    if (good !== 2 || other !== 0) $display("FAIL tie_ifu_beats: got good=%0d other=%0d want 2/0", good, other);
    else passes++;
    ar_handshake(cyc, to_s1, addr, len);
    checks++;
    if (cyc !== 1 || to_s1 !== 1'b1) $display("FAIL tie_lsu_turnaround: got lat=%0d s1=%b want lat=1 s1=1", cyc, to_s1);
    else passes++;
    serve_read(1'b1, 1, 0, 32'h4444_0000, RESP_OKAY, -1, good, other, stall_ok, rresp);
    S0_AXI_ARVALID = 1'b1; S0_AXI_ARADDR = 32'h3000_0300; S0_AXI_ARLEN = 8'd0;
    S1_AXI_ARVALID = 1'b1; S1_AXI_ARADDR = 32'h8000_2100; S1_AXI_ARLEN = 8'd0;
    ar_handshake(cyc, to_s1, addr, len);
    checks++;
    if (to_s1 !== 1'b0) $display("FAIL tie_again_ifu: got s1=%b want 0", to_s1);
    else passes++;
    serve_read(1'b0, 1, 0, 32'h5555_0000, RESP_OKAY, -1, good, other, stall_ok, rresp);
    ar_handshake(cyc, to_s1, addr, len);
    serve_read(1'b1, 1, 0, 32'h5656_0000, RESP_OKAY, -1, good, other, stall_ok, rresp);
    checks++;
    if (to_s1 !== 1'b1 || good !== 1) $display("FAIL tie_lsu_second: got s1=%b good=%0d want 1/1", to_s1, good);
    else passes++;
  endtask

  task automatic test_ifu_burst();
    S0_AXI_ARVALID = 1'b1; S0_AXI_ARADDR = 32'h3000_0000; S0_AXI_ARLEN = 8'd3;
    S0_AXI_ARSIZE = 3'd2; S0_AXI_ARBURST = 2'd1;
    ar_handshake(cyc, to_s1, addr, len);
    checks++;
    if (cyc !== 1 || addr !== 32'h3000_0000 || len !== 8'd3 || to_s1 !== 1'b0)
      $display("FAIL ifu_ar: got lat=%0d addr=%h len=%0d s1=%b want 1/30000000/3/0", cyc, addr, len, to_s1);
    else passes++;
    serve_read(1'b0, 4, 3, 32'hA000_0000, RESP_OKAY, -1, good, other, stall_ok, rresp);
    checks++;
    if (good !== 4 || other !== 0) $display("FAIL ifu_beats: got good=%0d other=%0d want 4/0", good, other);
    else passes++;
    #1;
    checks++;
    if (ctl_any() !== 1'b0) $display("FAIL ifu_idle_after_rlast: got %b want 0", ctl_any());
    else passes++;
  endtask

  task automatic test_store();
    S0_AXI_ARVALID = 1'b1; S0_AXI_ARADDR = 32'h3000_0400; S0_AXI_ARLEN = 8'd0;
    S1_AXI_AWVALID = 1'b1; S1_AXI_AWADDR = 32'h8000_0010; S1_AXI_AWLEN = 8'd0;
    S1_AXI_AWSIZE = 3'd2; S1_AXI_AWBURST = 2'd1; S1_AXI_AWID = 4'h2;
    S1_AXI_WVALID = 1'b1; S1_AXI_WDATA = 32'hDEAD_BEEF; S1_AXI_WSTRB = 4'hF; S1_AXI_WLAST = 1'b1;
    cyc = 0;
    #1;
    while (M_AXI_AWVALID !== 1'b1 && cyc < 20) begin
      @(negedge clock); #1; cyc++;
    end
    checks++;
    if (cyc !== 1 || M_AXI_AWADDR !== 32'h8000_0010 || M_AXI_ARVALID !== 1'b0)
      $display("FAIL store_aw: got lat=%0d addr=%h arvalid=%b want 1/80000010/0", cyc, M_AXI_AWADDR, M_AXI_ARVALID);
    else passes++;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    #1;
    checks++;
    if (S1_AXI_AWREADY !== 1'b1 || S1_AXI_WREADY !== 1'b1 || M_AXI_WDATA !== 32'hDEAD_BEEF ||
        M_AXI_WSTRB !== 4'hF || M_AXI_WLAST !== 1'b1 || M_AXI_AWID !== 4'h2)
      $display("FAIL store_w: got awr=%b wr=%b data=%h strb=%h last=%b id=%h want 1/1/deadbeef/f/1/2",
               S1_AXI_AWREADY, S1_AXI_WREADY, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_AWID);
    else passes++;
    @(negedge clock);
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; S1_AXI_AWVALID = 1'b0; S1_AXI_WVALID = 1'b0;
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = RESP_OKAY; M_AXI_BID = 4'h2; S1_AXI_BREADY = 1'b1;
    #1;
    checks++;
    if (S1_AXI_BVALID !== 1'b1 || S1_AXI_BRESP !== RESP_OKAY || S1_AXI_BID !== 4'h2 ||
        M_AXI_BREADY !== 1'b1 || M_AXI_ARVALID !== 1'b0)
      $display("FAIL store_b: got bv=%b resp=%b id=%h bready=%b arvalid=%b want 1/00/2/1/0",
               S1_AXI_BVALID, S1_AXI_BRESP, S1_AXI_BID, M_AXI_BREADY, M_AXI_ARVALID);
    else passes++;
    @(negedge clock);
    M_AXI_BVALID = 1'b0;
    #1;
    checks++;
    if (ctl_any() !== 1'b0) $display("FAIL store_idle: got %b want 0", ctl_any());
    else passes++;
    ar_handshake(cyc, to_s1, addr, len);
    checks++;
    if (cyc !== 1 || to_s1 !== 1'b0 || addr !== 32'h3000_0400)
      $display("FAIL store_then_ifu: got lat=%0d s1=%b addr=%h want 1/0/30000400", cyc, to_s1, addr);
    else passes++;
    serve_read(1'b0, 1, 0, 32'h6666_0000, RESP_OKAY, -1, good, other, stall_ok, rresp);
  endtask

  task automatic test_slverr();
    S1_AXI_ARVALID = 1'b1; S1_AXI_ARADDR = 32'h8000_3000; S1_AXI_ARLEN = 8'd0;
    ar_handshake(cyc, to_s1, addr, len);
    serve_read(1'b1, 1, 0, 32'h7777_0000, RESP_SLVERR, -1, good, other, stall_ok, rresp);
    checks++;
    if (to_s1 !== 1'b1 || good !== 1 || rresp !== RESP_SLVERR)
      $display("FAIL slverr_pass: got s1=%b good=%0d resp=%b want 1/1/10", to_s1, good, rresp);
    else passes++;
    #1;
    checks++;
    if (ctl_any() !== 1'b0) $display("FAIL slverr_idle: got %b want 0", ctl_any());
    else passes++;
  endtask

  task automatic test_rready_stall();
    S0_AXI_ARVALID = 1'b1; S0_AXI_ARADDR = 32'h3000_0800; S0_AXI_ARLEN = 8'd3;
    ar_handshake(cyc, to_s1, addr, len);
    serve_read(1'b0, 4, 3, 32'hB000_0000, RESP_OKAY, 1, good, other, stall_ok, rresp);
    checks++;
    if (stall_ok !== 3) $display("FAIL stall_rready_low: got %0d want 3", stall_ok);
    else passes++;
    checks++;
    if (good !== 4 || other !== 0) $display("FAIL stall_beats: got good=%0d other=%0d want 4/0", good, other);
    else passes++;
    #1;
    checks++;
    if (ctl_any() !== 1'b0) $display("FAIL stall_idle: got %b want 0", ctl_any());
    else passes++;
  endtask

  initial begin
    i_rst = 1'b1;
    S0_AXI_ARADDR = 32'h0; S0_AXI_ARVALID = 1'b0; S0_AXI_ARID = 4'h3; S0_AXI_ARLEN = 8'd0;
    S0_AXI_ARSIZE = 3'd2; S0_AXI_ARBURST = 2'd1; S0_AXI_RREADY = 1'b0;
    S1_AXI_ARADDR = 32'h0; S1_AXI_ARVALID = 1'b0; S1_AXI_ARID = 4'h5; S1_AXI_ARLEN = 8'd0;
    S1_AXI_ARSIZE = 3'd2; S1_AXI_ARBURST = 2'd1; S1_AXI_RREADY = 1'b0;
    S1_AXI_AWADDR = 32'h0; S1_AXI_AWVALID = 1'b0; S1_AXI_AWLEN = 8'd0; S1_AXI_AWSIZE = 3'd0;
    S1_AXI_AWBURST = 2'd0; S1_AXI_AWID = 4'h0; S1_AXI_WVALID = 1'b0; S1_AXI_WDATA = 32'h0;
    S1_AXI_WSTRB = 4'h0; S1_AXI_WLAST = 1'b0; S1_AXI_BREADY = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00; M_AXI_RVALID = 1'b0;
    M_AXI_RID = 4'h0; M_AXI_RLAST = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0; M_AXI_BID = 4'h0;
    test_reset();
    test_tie();
    test_ifu_burst();
    test_store();
    test_slverr();
    test_rready_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_axi_arbiter.md
# ysyx_23060124_axi_arbiter

Two-master to one-slave AXI4 arbiter that shares the single memory port between the IFU (read-only, master 0) and the EXU/LSU (read and write, master 1). It serialises all traffic: exactly one transaction (read burst or single write) is in flight at a time, chosen by round-robin between IFU and LSU. It sits between the core's fetch/execute units and the SoC crossbar.

## Interface
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of R/W channels (WSTRB = DATA_W/8)

- clock  in  1  core clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- S0_AXI_AR{ADDR,VALID,ID,LEN,SIZE,BURST} / S0_AXI_ARREADY  in / out  ADDR_W,1,4,8,3,2 / 1  IFU read address
- S0_AXI_R{DATA,RESP,VALID,ID,LAST} / S0_AXI_RREADY  out / in  DATA_W,2,1,4,1 / 1  IFU read data
- S1_AXI_AR*, S1_AXI_R*  same as S0  LSU read channels
- S1_AXI_AW{ADDR,VALID,LEN,SIZE,BURST,ID} / S1_AXI_AWREADY  in / out  ADDR_W,1,8,3,2,4 / 1  LSU write address
- S1_AXI_W{VALID,DATA,STRB,LAST} / S1_AXI_WREADY  in / out  1,DATA_W,DATA_W/8,1 / 1  LSU write data
- S1_AXI_B{RESP,VALID,ID} / S1_AXI_BREADY  out / in  2,1,4 / 1  LSU write response
- M_AXI_AR*, M_AXI_R*, M_AXI_AW*, M_AXI_W*, M_AXI_B*  mirrored directions, same widths  memory-side AXI4 master

## Operation
- FSM states: IDLE, RD_IFU, RD_LSU, WR_LSU. Register last_lsu (1 = LSU granted most recently).
- IDLE: no channel routed; all M_AXI_*VALID, M_AXI_RREADY, M_AXI_BREADY, all S*_READY, all S*_VALID = 0.
- IDLE requests: ifu_req = S0_ARVALID; lsu_req = S1_ARVALID | S1_AWVALID.
  - only ifu_req -> RD_IFU; only lsu_req -> WR_LSU if S1_AWVALID else RD_LSU.
  - both -> IFU if last_lsu=1, else LSU. LSU with both AW and AR valid: write first.
- On leaving IDLE, last_lsu <= (next state != RD_IFU).
- RD_x: master x's AR and R channels wired straight through to M_AXI_AR/R (payload and handshakes combinational); other master sees READY=0/VALID=0; AW/W/B closed. Exit to IDLE on M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST.
- WR_LSU: S1 AW, W, B wired to M_AXI; AR/R closed. Exit to IDLE on M_AXI_BVALID & M_AXI_BREADY.
- RRESP/BRESP/ID passed through unmodified; errors do not alter sequencing.
- Unrouted M_AXI payload outputs driven 0 (not just don't-care), for waveform clarity.
- Reset (any time, incl. mid-burst): state <= IDLE, last_lsu <= 1; all outputs 0 while i_rst high. In-flight transaction abandoned; masters restart.

## Timing
- Arbitration latency: request visible in IDLE at cycle t -> grant state at t+1, M_AXI_ARVALID/AWVALID high at t+1.
- Transaction end: final R (or B) handshake at cycle k -> IDLE at k+1 -> next grant earliest k+2. Two-cycle turnaround, no back-to-back grant.
- Requests arriving during a grant wait; masters must hold VALID (AXI rule).
- R/B handshakes in the granted state have zero added latency (pure combinational path).
- Multi-beat bursts (ARLEN>0) hold the grant until the RLAST beat.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, RD_IFU=2'd1, RD_LSU=2'd2, WR_LSU=2'd3), AXI RESP constants (OKAY/SLVERR/DECERR), ID widths.
- One natural sub-module: ysyx_23060124_rr_pick2 (2-way round-robin picker from ifu_req, lsu_req, last_lsu -> grant). Routing muxes stay inline.

## Test plan
- Reset mid-RD_LSU burst (i_rst pulse at beat 2 of 4) -> all M/S valid/ready 0 during reset, state IDLE, next IFU request granted at +1 cycle.
- IFU alone reads 0x3000_0000 ARLEN=3 -> M_AXI_ARVALID at t+1, four beats forwarded to S0, IDLE on RLAST cycle+1, S1 never sees RVALID.
- IFU and LSU read valid same cycle after reset -> IFU first (last_lsu=1), LSU granted at IFU RLAST+2, then a further tie goes to IFU.
- LSU store 0x8000_0010 data 0xDEADBEEF strb 0xF while IFU AR pending -> tie resolved per last_lsu; write completes, BRESP=OKAY returned to S1, IFU AR not forwarded until WR_LSU exits.
- Slave returns RRESP=SLVERR on LSU load -> passed to S1_AXI_RRESP unchanged, state returns to IDLE normally.
- RREADY held low 3 cycles by IFU during burst -> M_AXI_RREADY low same cycles, grant held, no beat lost.
